// File: rtl/motor_ctrl_pkg.sv
// Shared encodings for the motor ramp controller: tracker modes, FSM state codes,
// wheel target table and the duty slew helper.
package motor_ctrl_pkg;

  localparam logic [2:0] MODE_LEFT        = 3'b000;
  localparam logic [2:0] MODE_RIGHT       = 3'b001;
  localparam logic [2:0] MODE_STRAIGHT    = 3'b010;
  localparam logic [2:0] MODE_STOP        = 3'b011;
  localparam logic [2:0] MODE_SHARP_LEFT  = 3'b100;
  localparam logic [2:0] MODE_SHARP_RIGHT = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KICK  = 3'd1,
    ST_RAMP  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_BRAKE = 3'd4
  } state_t;

  localparam logic [9:0] DUTY_FULL  = 10'd1023;
  localparam logic [9:0] DUTY_TURN  = 10'd768;
  localparam logic [9:0] DUTY_SHARP = 10'd512;
  localparam logic [9:0] DUTY_OFF   = 10'd0;

  // Returns {left_target, right_target}; unused codes fall back to stop.
  function automatic logic [19:0] mode_targets(input logic [2:0] m);
    case (m)
      MODE_LEFT:        return {DUTY_TURN,  DUTY_FULL};
      MODE_RIGHT:       return {DUTY_FULL,  DUTY_TURN};
      MODE_STRAIGHT:    return {DUTY_FULL,  DUTY_FULL};
      MODE_SHARP_LEFT:  return {DUTY_SHARP, DUTY_FULL};
      MODE_SHARP_RIGHT: return {DUTY_FULL,  DUTY_SHARP};
      default:          return {DUTY_OFF,   DUTY_OFF};
    endcase
  endfunction

  // One slew step toward tgt; comparisons are done in 11 bits so cur+step never wraps.
  function automatic logic [9:0] slew(input logic [9:0] cur, input logic [9:0] tgt,
                                      input logic [9:0] step);
    logic [10:0] c;
    logic [10:0] t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t > c + {1'b0, step}) return cur + step;
    if (c > t + {1'b0, step}) return cur - step;
    return tgt;
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running divider: counts 0..TICK_DIV-1 and flags the last count as the ramp tick.
module ramp_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Two-wheel duty ramp controller: mode latch, target table, IDLE/KICK/RAMP/HOLD/BRAKE FSM.
// Define MOTOR_KICKSTART_EN to build the full-duty kick phase; otherwise IDLE starts at MIN_RUN_DUTY.
module motor_ramp_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int STEP         = 16,
  parameter int KICK_TICKS   = 20,
  parameter int MIN_RUN_DUTY = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] mode,
  input  logic       mode_valid,
  output logic [9:0] left_duty,
  output logic [9:0] right_duty,
  output logic       settled,
  output logic [2:0] state_o
);

  localparam logic [9:0] MIN_DUTY = MIN_RUN_DUTY[9:0];
  localparam logic [9:0] STEP_D   = STEP[9:0];

  logic tick;

  ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [2:0] mode_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg <= MODE_STOP;
    end else if (mode_valid) begin
      mode_reg <= mode;
    end
  end

  state_t     state_reg, state_next;
  logic [9:0] left_duty_reg, left_duty_next;
  logic [9:0] right_duty_reg, right_duty_next;
  logic       settled_reg, settled_next;

  logic [19:0] tgt_pair;
  logic [9:0]  tgt_raw [2];
  logic [9:0]  tgt     [2];
  logic [9:0]  duty_cur[2];
  logic [9:0]  duty_slw[2];

  assign tgt_pair    = mode_targets(mode_reg);
  assign tgt_raw[0]  = tgt_pair[19:10];
  assign tgt_raw[1]  = tgt_pair[9:0];
  assign duty_cur[0] = left_duty_reg;
  assign duty_cur[1] = right_duty_reg;

  // Per wheel: lift nonzero targets to the minimum running duty, then compute the next slew value.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wheel
      assign tgt[gi] = (tgt_raw[gi] != DUTY_OFF && tgt_raw[gi] < MIN_DUTY) ? MIN_DUTY : tgt_raw[gi];
      assign duty_slw[gi] = slew(duty_cur[gi], tgt[gi], STEP_D);
    end
  endgenerate

  logic both_zero, at_target, stop_req;
  assign both_zero = (tgt[0] == DUTY_OFF) && (tgt[1] == DUTY_OFF);
  assign at_target = (left_duty_reg == tgt[0]) && (right_duty_reg == tgt[1]);
  assign stop_req  = !enable || both_zero;

`ifdef MOTOR_KICKSTART_EN
  localparam int KW = (KICK_TICKS > 1) ? $clog2(KICK_TICKS + 1) : 1;
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_TICKS - 1);
  logic [KW-1:0] kick_cnt_reg, kick_cnt_next;
`endif

  always_comb begin
    state_next      = state_reg;
    left_duty_next  = left_duty_reg;
    right_duty_next = right_duty_reg;
    settled_next    = 1'b0;
`ifdef MOTOR_KICKSTART_EN
    kick_cnt_next   = kick_cnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        left_duty_next  = DUTY_OFF;
        right_duty_next = DUTY_OFF;
        if (enable && !both_zero) begin
`ifdef MOTOR_KICKSTART_EN
          state_next      = ST_KICK;
          left_duty_next  = DUTY_FULL;
          right_duty_next = DUTY_FULL;
          kick_cnt_next   = '0;
`else
          state_next      = ST_RAMP;
          left_duty_next  = MIN_DUTY;
          right_duty_next = MIN_DUTY;
`endif
        end
      end
`ifdef MOTOR_KICKSTART_EN
      ST_KICK: begin
        if (stop_req) begin
          state_next      = ST_BRAKE;
          left_duty_next  = DUTY_OFF;
          right_duty_next = DUTY_OFF;
        end else begin
          left_duty_next  = DUTY_FULL;
          right_duty_next = DUTY_FULL;
          if (tick) begin
            if (kick_cnt_reg == KICK_LAST) state_next = ST_RAMP;
            else kick_cnt_next = kick_cnt_reg + KW'(1);
          end
        end
      end
`endif
      ST_RAMP: begin
        if (stop_req) begin
          state_next      = ST_BRAKE;
          left_duty_next  = DUTY_OFF;
          right_duty_next = DUTY_OFF;
        end else if (at_target) begin
          state_next   = ST_HOLD;
          settled_next = 1'b1;
        end else if (tick) begin
          left_duty_next  = duty_slw[0];
          right_duty_next = duty_slw[1];
        end
      end
      ST_HOLD: begin
        if (stop_req) begin
          state_next      = ST_BRAKE;
          left_duty_next  = DUTY_OFF;
          right_duty_next = DUTY_OFF;
        end else if (at_target) begin
          settled_next = 1'b1;
        end else begin
          state_next = ST_RAMP;
        end
      end
      ST_BRAKE: begin
        state_next      = ST_IDLE;
        left_duty_next  = DUTY_OFF;
        right_duty_next = DUTY_OFF;
      end
      default: begin
        state_next      = ST_IDLE;
        left_duty_next  = DUTY_OFF;
        right_duty_next = DUTY_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      left_duty_reg  <= DUTY_OFF;
      right_duty_reg <= DUTY_OFF;
      settled_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      left_duty_reg  <= left_duty_next;
      right_duty_reg <= right_duty_next;
      settled_reg    <= settled_next;
    end
  end

`ifdef MOTOR_KICKSTART_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) kick_cnt_reg <= '0;
    else     kick_cnt_reg <= kick_cnt_next;
  end
`endif

  assign left_duty  = left_duty_reg;
  assign right_duty = right_duty_reg;
  assign settled    = settled_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl (TICK_DIV=4, STEP=16, KICK_TICKS=2, MIN_RUN_DUTY=512).
// Follows the kick-phase expectations when MOTOR_KICKSTART_EN is defined.
module tb_motor_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] mode = 3'b000;
  logic       mode_valid = 1'b0;
  logic [9:0] left_duty;
  logic [9:0] right_duty;
  logic       settled;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  motor_ramp_ctrl #(
    .TICK_DIV(4), .STEP(16), .KICK_TICKS(2), .MIN_RUN_DUTY(512)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .mode_valid (mode_valid),
    .left_duty  (left_duty),
    .right_duty (right_duty),
    .settled    (settled),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int toward(int p, int t);
    if (t - p > 16) return p + 16;
    if (p - t > 16) return p - 16;
    return t;
  endfunction

  task automatic strobe(input logic [2:0] m);
    mode = m;
    mode_valid = 1'b1;
    cyc();
    mode_valid = 1'b0;
  endtask

  // Called on the first cycle after leaving IDLE; exits once in RAMP.
  task automatic check_entry(input string name);
`ifdef MOTOR_KICKSTART_EN
    int n;
    checks++;
    if (state_o !== 3'd1 || left_duty !== 10'd1023 || right_duty !== 10'd1023) begin
      errors++;
      $display("FAIL %s kick_entry: got state %0d duty %0d/%0d, expected 1 1023/1023", name, state_o, left_duty, right_duty);
    end
    n = 0;
    while (state_o === 3'd1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (state_o !== 3'd2 || n < 5 || n > 8) begin
      errors++;
      $display("FAIL %s kick_len: got state %0d after %0d cycles, expected state 2 after 5..8", name, state_o, n);
    end
`else
    checks++;
    if (state_o !== 3'd2 || left_duty !== 10'd512 || right_duty !== 10'd512) begin
      errors++;
      $display("FAIL %s ramp_entry: got state %0d duty %0d/%0d, expected 2 512/512", name, state_o, left_duty, right_duty);
    end
`endif
  endtask

  // Follows the ramp: every change must be one bounded step toward target, one tick (4 clocks) apart.
  task automatic wait_settle(input logic [9:0] tl, input logic [9:0] tr, input string name);
    logic [9:0] pl, pr, el, er;
    int last_chg;
    bit done;
    pl = left_duty;
    pr = right_duty;
    last_chg = -1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      cyc();
      if (left_duty !== pl || right_duty !== pr) begin
        el = 10'(toward(int'(pl), int'(tl)));
        er = 10'(toward(int'(pr), int'(tr)));
        checks++;
        if (left_duty !== el || right_duty !== er) begin
          errors++;
          $display("FAIL %s step: got %0d/%0d, expected %0d/%0d", name, left_duty, right_duty, el, er);
        end
        if (last_chg >= 0) begin
          checks++;
          if (i - last_chg != 4) begin
            errors++;
            $display("FAIL %s tick_gap: got %0d cycles, expected 4", name, i - last_chg);
          end
        end
        last_chg = i;
        pl = left_duty;
        pr = right_duty;
      end
      if (settled === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s settle_timeout: settled %b, expected 1 within 400 cycles", name, settled);
    end
    checks++;
    if (state_o !== 3'd3 || left_duty !== tl || right_duty !== tr) begin
      errors++;
      $display("FAIL %s hold: got state %0d duty %0d/%0d, expected 3 %0d/%0d", name, state_o, left_duty, right_duty, tl, tr);
    end
    $display("%s: settled at %0d/%0d", name, left_duty, right_duty);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if (state_o !== 3'd0 || left_duty !== 10'd0 || right_duty !== 10'd0 || settled !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got state %0d duty %0d/%0d settled %b, expected 0 0/0 0", state_o, left_duty, right_duty, settled);
    end
    rst = 1'b0;
    enable = 1'b1;
    repeat (4) cyc();
    checks++;
    if (state_o !== 3'd0 || left_duty !== 10'd0 || right_duty !== 10'd0) begin
      errors++;
      $display("FAIL reset_mode_stop: got state %0d duty %0d/%0d, expected IDLE 0/0", state_o, left_duty, right_duty);
    end
    $display("test_reset: state %0d", state_o);
  endtask

  task automatic test_idle_zero_code();
    strobe(3'b110);
    repeat (3) cyc();
    checks++;
    if (state_o !== 3'd0 || left_duty !== 10'd0 || right_duty !== 10'd0) begin
      errors++;
      $display("FAIL idle_code110: got state %0d duty %0d/%0d, expected IDLE 0/0", state_o, left_duty, right_duty);
    end
    $display("test_idle_zero_code: state %0d", state_o);
  endtask

  task automatic test_ramp_left();
    strobe(3'b000);
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL left_latch_delay: got state %0d, expected 0", state_o);
    end
    cyc();
    check_entry("ramp_left");
    wait_settle(10'd768, 10'd1023, "ramp_left");
  endtask

  task automatic test_hold_change();
    strobe(3'b100);
    cyc();
    checks++;
    if (state_o !== 3'd2 || settled !== 1'b0 || left_duty !== 10'd768) begin
      errors++;
      $display("FAIL hold_to_ramp: got state %0d settled %b left %0d, expected 2 0 768", state_o, settled, left_duty);
    end
    wait_settle(10'd512, 10'd1023, "sharp_left");
  endtask

  task automatic test_straight();
    strobe(3'b010);
    wait_settle(10'd1023, 10'd1023, "straight");
  endtask

  task automatic test_brake_strobe();
    strobe(3'b101);
    cyc();
    checks++;
    if (state_o !== 3'd2) begin
      errors++;
      $display("FAIL brake_pre_ramp: got state %0d, expected 2", state_o);
    end
    enable = 1'b0;
    strobe(3'b001);
    checks++;
    if (state_o !== 3'd4 || left_duty !== 10'd0 || right_duty !== 10'd0 || settled !== 1'b0) begin
      errors++;
      $display("FAIL brake_entry: got state %0d duty %0d/%0d settled %b, expected 4 0/0 0", state_o, left_duty, right_duty, settled);
    end
    cyc();
    checks++;
    if (state_o !== 3'd0 || left_duty !== 10'd0 || right_duty !== 10'd0) begin
      errors++;
      $display("FAIL brake_to_idle: got state %0d duty %0d/%0d, expected 0 0/0", state_o, left_duty, right_duty);
    end
    enable = 1'b1;
    cyc();
    check_entry("brake_relatch");
    wait_settle(10'd1023, 10'd768, "right_after_brake");
  endtask

  task automatic test_stop();
    strobe(3'b011);
    cyc();
    checks++;
    if (state_o !== 3'd4 || left_duty !== 10'd0 || right_duty !== 10'd0 || settled !== 1'b0) begin
      errors++;
      $display("FAIL stop_brake: got state %0d duty %0d/%0d settled %b, expected 4 0/0 0", state_o, left_duty, right_duty, settled);
    end
    cyc();
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL stop_idle: got state %0d, expected 0", state_o);
    end
    $display("test_stop: state %0d", state_o);
  endtask

  task automatic test_async_reset();
    strobe(3'b010);
    cyc();
    checks++;
    if (state_o === 3'd0) begin
      errors++;
      $display("FAIL async_pre: got state %0d, expected active state", state_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state_o !== 3'd0 || left_duty !== 10'd0 || right_duty !== 10'd0 || settled !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got state %0d duty %0d/%0d settled %b, expected 0 0/0 0", state_o, left_duty, right_duty, settled);
    end
    cyc();
    rst = 1'b0;
    repeat (6) cyc();
    checks++;
    if (state_o !== 3'd0 || left_duty !== 10'd0 || right_duty !== 10'd0) begin
      errors++;
      $display("FAIL async_restart_idle: got state %0d duty %0d/%0d, expected 0 0/0", state_o, left_duty, right_duty);
    end
    $display("test_async_reset: state %0d", state_o);
  endtask

  initial begin
    test_reset();
    test_idle_zero_code();
    test_ramp_left();
    test_hold_change();
    test_straight();
    test_brake_strobe();
    test_stop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
